// File: rtl/hub75_pkg.sv
// Shared HUB75 panel constants, scan-state encoding and pixel-bus layout.
// Game logic and the bench import this to stay in step with the scanner.
package hub75_pkg;

  localparam int COLS      = 32;
  localparam int COL_W     = 5;
  localparam int ROW_W     = 4;
  localparam int ON_CYCLES = 256;
  localparam int ADDR_W    = 1 + ROW_W + COL_W;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    SETUP,
    CLK,
    BLANK,
    LATCH,
    DISPLAY
  } state_t;

  // Bit positions inside the 6-bit {R0,G0,B0,R1,G1,B1} pixel bus
  localparam int PIX_R0 = 5;
  localparam int PIX_G0 = 4;
  localparam int PIX_B0 = 3;
  localparam int PIX_R1 = 2;
  localparam int PIX_G1 = 1;
  localparam int PIX_B1 = 0;

  // Clocks spent on one row pair: prime + shift + blank + latch + display
  function automatic int row_cycles(input int cols, input int on_cycles, input int dim);
    return 3 + 2 * cols + (on_cycles >> dim);
  endfunction

endpackage

// File: rtl/hub75_on_timer.sv
// Row on-time down-counter: loaded with on_cycles >> dim, flags the final
// display cycle so the scanner can leave DISPLAY on time.
module hub75_on_timer #(
  parameter int ON_CYCLES = 256,
  parameter int CNT_W     = $clog2(ON_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] dim,
  output logic       done
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CNT_W'(ON_CYCLES >> dim);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // dim is captured only at load, so a change mid-row has no effect
  assign done = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 1/16-scan sequencer: shifts each row pair out of the displayed
// framebuffer, latches it, then lights it for a dim-scaled on-time.
module hub75_scan_ctrl #(
  parameter int COLS      = hub75_pkg::COLS,
  parameter int COL_W     = hub75_pkg::COL_W,
  parameter int ROW_W     = hub75_pkg::ROW_W,
  parameter int ON_CYCLES = hub75_pkg::ON_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             dim,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   fb_sel,
  output logic [ROW_W+COL_W:0]   rd_addr,
  input  logic [5:0]             rd_data,
  output logic                   frame_start,
  output logic                   A,
  output logic                   B,
  output logic                   C,
  output logic                   D,
  output logic                   R0,
  output logic                   G0,
  output logic                   B0,
  output logic                   R1,
  output logic                   G1,
  output logic                   B1,
  output logic                   SCLK,
  output logic                   LAT,
  output logic                   OE
);
  import hub75_pkg::*;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = '1;

  state_t             state_reg, state_next;
  logic [ROW_W-1:0]   row_reg, row_next;
  logic [COL_W-1:0]   col_reg, col_next, col_inc;
  logic               fb_sel_reg, fb_sel_next;
  logic               swap_ack_reg, swap_ack_next;
  logic [ROW_W+COL_W:0] rd_addr_reg, rd_addr_next;
  logic [5:0]         rgb_reg, rgb_next;
  logic [ROW_W-1:0]   ad_reg, ad_next;
  logic               sclk_reg, sclk_next;
  logic               lat_reg, lat_next;
  logic               oe_reg, oe_next;
  logic               fs_reg, fs_next;
  logic               timer_load, timer_done;

  assign col_inc    = col_reg + 1'b1;
  assign timer_load = (state_reg == LATCH);

  hub75_on_timer #(
    .ON_CYCLES(ON_CYCLES)
  ) u_on_timer (
    .clk (clk),
    .rst (rst),
    .load(timer_load),
    .dim (dim),
    .done(timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      row_reg      <= '0;
      col_reg      <= '0;
      fb_sel_reg   <= 1'b0;
      swap_ack_reg <= 1'b0;
      rd_addr_reg  <= '0;
      rgb_reg      <= '0;
      ad_reg       <= '0;
      sclk_reg     <= 1'b0;
      lat_reg      <= 1'b0;
      oe_reg       <= 1'b1;
      fs_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row_reg      <= row_next;
      col_reg      <= col_next;
      fb_sel_reg   <= fb_sel_next;
      swap_ack_reg <= swap_ack_next;
      rd_addr_reg  <= rd_addr_next;
      rgb_reg      <= rgb_next;
      ad_reg       <= ad_next;
      sclk_reg     <= sclk_next;
      lat_reg      <= lat_next;
      oe_reg       <= oe_next;
      fs_reg       <= fs_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    row_next      = row_reg;
    col_next      = col_reg;
    fb_sel_next   = fb_sel_reg;
    swap_ack_next = 1'b0;
    case (state_reg)
      IDLE:    if (en) state_next = PRIME;
      PRIME: begin
        col_next   = '0;
        state_next = SETUP;
      end
      SETUP:   state_next = CLK;
      CLK: begin
        if (col_reg == LAST_COL) begin
          state_next = BLANK;
        end else begin
          col_next   = col_inc;
          state_next = SETUP;
        end
      end
      BLANK:   state_next = LATCH;
      LATCH:   state_next = DISPLAY;
      DISPLAY: begin
        if (timer_done) begin
          state_next = en ? PRIME : IDLE;
          // Frame boundary is the only point a buffer swap may happen
          if (row_reg == LAST_ROW) begin
            row_next = '0;
            if (swap_req) begin
              fb_sel_next   = ~fb_sel_reg;
              swap_ack_next = 1'b1;
            end
          end else if (en) begin
            row_next = row_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin values are derived from the upcoming state so every pin is a flop
  always_comb begin
    rd_addr_next = rd_addr_reg;
    rgb_next     = rgb_reg;
    ad_next      = ad_reg;
    case (state_next)
      PRIME:   rd_addr_next = {fb_sel_next, row_next, {COL_W{1'b0}}};
      CLK:     rd_addr_next = {fb_sel_reg, row_reg, col_inc};
      default: ;
    endcase
    if (state_reg == SETUP) rgb_next = rd_data;
    if (state_next == LATCH) ad_next = row_reg;
    sclk_next = (state_next == CLK);
    lat_next  = (state_next == LATCH);
    oe_next   = (state_next != DISPLAY);
    fs_next   = (state_next == PRIME) && (row_next == '0);
  end

  assign swap_ack    = swap_ack_reg;
  assign fb_sel      = fb_sel_reg;
  assign rd_addr     = rd_addr_reg;
  assign frame_start = fs_reg;
  assign A           = ad_reg[0];
  assign B           = ad_reg[1];
  assign C           = ad_reg[2];
  assign D           = ad_reg[3];
  assign R0          = rgb_reg[PIX_R0];
  assign G0          = rgb_reg[PIX_G0];
  assign B0          = rgb_reg[PIX_B0];
  assign R1          = rgb_reg[PIX_R1];
  assign G1          = rgb_reg[PIX_G1];
  assign B1          = rgb_reg[PIX_B1];
  assign SCLK        = sclk_reg;
  assign LAT         = lat_reg;
  assign OE          = oe_reg;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: row-by-row vector table with a pixel scoreboard,
// plus hand sequences for the en-drop pause and a mid-display reset.
module tb_hub75_scan_ctrl;
  import hub75_pkg::*;

  logic clk = 1'b0;
  logic rst, en, swap_req;
  logic [1:0] dim;
  logic [5:0] rd_data;
  logic swap_ack, fb_sel, frame_start;
  logic [ADDR_W-1:0] rd_addr;
  logic A, B, C, D, R0, G0, B0, R1, G1, B1, SCLK, LAT, OE;

  hub75_scan_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .dim(dim), .swap_req(swap_req),
    .swap_ack(swap_ack), .fb_sel(fb_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_start(frame_start), .A(A), .B(B), .C(C), .D(D),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .SCLK(SCLK), .LAT(LAT), .OE(OE)
  );

  always #5 clk = ~clk;

  // Framebuffer model with one-cycle read latency; pixel = {buffer, column}
  always @(posedge clk) rd_data <= {rd_addr[ADDR_W-1], rd_addr[COL_W-1:0]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   row;
    logic fb;
    int   dim;
    int   dim_mid;
    logic swap;
    logic ack;
    logic en;
    int   gap;
  } rec_t;

  rec_t tbl[$];
  logic [5:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int prev_ad = 0;
  int last_fs = -1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [25:0] pin_vec();
    return {OE, LAT, SCLK, D, C, B, A, fb_sel, swap_ack, frame_start,
            R0, G0, B0, R1, G1, B1, rd_addr};
  endfunction

  function automatic rec_t mk(input int row, input logic fb, input int d, input int dm,
                              input logic sw, input logic ack, input logic e, input int gap);
    rec_t r;
    r.row = row; r.fb = fb; r.dim = d; r.dim_mid = dm;
    r.swap = sw; r.ack = ack; r.en = e; r.gap = gap;
    return r;
  endfunction

  // Entered at the negedge of the PRIME cycle; leaves at the last DISPLAY negedge
  task automatic run_row(input rec_t r);
    int on = ON_CYCLES >> r.dim;
    int pix_bad = 0, sclk_cnt = 0, lat_pos = -1, lat_cnt = 0;
    int oe_low = 0, oe_bad = 0, ad_bad = 0, ack_extra = 0;
    logic [5:0] e;
    logic [5:0] pix;
    logic [3:0] ad_now;
    logic [3:0] row4;
    logic [4:0] kk;
    row4 = r.row[3:0];
    dim = r.dim[1:0];
    swap_req = r.swap;
    check($sformatf("r%0d prime_addr", r.row), 32'(rd_addr), 32'({r.fb, row4, 5'd0}));
    check($sformatf("r%0d frame_start", r.row), 32'(frame_start), 32'(r.row == 0));
    check($sformatf("r%0d swap_ack", r.row), 32'(swap_ack), 32'(r.ack));
    check($sformatf("r%0d fb_sel", r.row), 32'(fb_sel), 32'(r.fb));
    if (r.gap != 0) check("frame_gap", 32'(cyc - last_fs), 32'(r.gap));
    if (frame_start === 1'b1) last_fs = cyc;
    for (int k = 0; k < COLS; k++) begin
      kk = k[4:0];
      exp_q.push_back({r.fb, kk});
    end
    if (OE !== 1'b1) oe_bad++;
    for (int c = 1; c <= 66 + on; c++) begin
      @(negedge clk);
      if (c == 3) en = r.en;
      if (c == 80) dim = r.dim_mid[1:0];
      pix = {R0, G0, B0, R1, G1, B1};
      if (SCLK === 1'b1) begin
        sclk_cnt++;
        if (exp_q.size() == 0) pix_bad++;
        else begin
          e = exp_q.pop_front();
          if (pix !== e) pix_bad++;
        end
      end
      if (LAT === 1'b1) begin
        lat_cnt++;
        lat_pos = c;
      end
      if (c >= 67) begin
        if (OE === 1'b0) oe_low++;
        else oe_bad++;
      end else if (OE !== 1'b1) oe_bad++;
      ad_now = {D, C, B, A};
      if (c >= 66) begin
        if (ad_now !== row4) ad_bad++;
      end else if (32'(ad_now) != prev_ad) ad_bad++;
      if (swap_ack !== 1'b0) ack_extra++;
    end
    exp_q.delete();
    check($sformatf("r%0d pixel_errs", r.row), 32'(pix_bad), 32'd0);
    check($sformatf("r%0d sclk_pulses", r.row), 32'(sclk_cnt), 32'(COLS));
    check($sformatf("r%0d lat_pos", r.row), 32'(lat_pos), 32'd66);
    check($sformatf("r%0d lat_cnt", r.row), 32'(lat_cnt), 32'd1);
    check($sformatf("r%0d oe_low", r.row), 32'(oe_low), 32'(on));
    check($sformatf("r%0d oe_errs", r.row), 32'(oe_bad), 32'd0);
    check($sformatf("r%0d ad_errs", r.row), 32'(ad_bad), 32'd0);
    check($sformatf("r%0d extra_ack", r.row), 32'(ack_extra), 32'd0);
    prev_ad = r.row;
    $display("row %0d fb=%0d dim=%0d sclk=%0d lat@%0d oe_low=%0d", r.row, r.fb, r.dim,
             sclk_cnt, lat_pos, oe_low);
  endtask

  initial begin
    int idle_bad;
    rst = 1'b1; en = 1'b0; dim = 2'd0; swap_req = 1'b0;

    for (int f = 0; f < 3; f++) begin
      for (int row = 0; row < 16; row++) begin
        int d;
        int dm;
        logic sw;
        d  = (f == 0) ? 0 : 3;
        dm = d;
        if (f == 1 && row == 0) begin
          d  = 2;
          dm = 0;
        end
        sw = (f == 0 && row >= 5 && row <= 8) || (f == 1 && row >= 3) || (f == 2 && row <= 3);
        tbl.push_back(mk(row, f == 2, d, dm, sw, f == 2 && row == 0, 1'b1,
                         (f == 1 && row == 0) ? 5168 : 0));
      end
    end
    for (int row = 0; row <= 5; row++) tbl.push_back(mk(row, 1'b1, 3, 3, 1'b0, 1'b0, row != 5, 0));
    for (int row = 5; row <= 8; row++) tbl.push_back(mk(row, 1'b1, 3, 3, 1'b0, 1'b0, 1'b1, 0));

    repeat (3) @(negedge clk);
    check("reset_pins", 32'(pin_vec()), 32'({1'b1, 25'd0}));
    rst = 1'b0;
    en = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_row(tbl[i]);
      @(negedge clk);
      if (tbl[i].en == 1'b0) begin
        idle_bad = 0;
        for (int k = 0; k < 10; k++) begin
          if (OE !== 1'b1 || frame_start !== 1'b0 || SCLK !== 1'b0 || LAT !== 1'b0) idle_bad++;
          @(negedge clk);
        end
        check("pause_idle_errs", 32'(idle_bad), 32'd0);
        $display("paused after row %0d, re-enabling", tbl[i].row);
        en = 1'b1;
        @(negedge clk);
      end
    end

    // Row 9: reset in the middle of DISPLAY
    repeat (70) @(negedge clk);
    check("r9 oe_before_rst", 32'(OE), 32'd0);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    check("mid_rst_pins", 32'(pin_vec()), 32'({1'b1, 25'd0}));
    @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (OE !== 1'b1 || frame_start !== 1'b0 || SCLK !== 1'b0 || LAT !== 1'b0) idle_bad++;
    end
    check("post_rst_idle_errs", 32'(idle_bad), 32'd0);
    $display("reset during row 9 display handled");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
